glb_psum_accum: RTL and testbench

//  Psum global-buffer bank directly downstream of the psum router. Takes the serial
//  (write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum) stream and stores each word.
//  In accumulate mode it read-modify-writes (mem += data, signed saturating), so psums

---
 rtl/glb_psum_accum.sv | 137 +++++++++++++
 tb/tb_glb_psum_accum.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/glb_psum_accum.sv
// Psum global-buffer bank: stores or signed-saturating-accumulates router psums, with a registered read port.
// Write: 2-stage pipe (capture+old read, then compute+commit). Read: 1-cycle latency. No backpressure; busy while clearing.
module glb_psum_accum #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int DEPTH             = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_en_glb_psum,
  input  logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]     w_data_glb_psum,
  input  logic                         accum_en,
  input  logic                         clear,
  input  logic                         read_en,
  input  logic [ADDR_BITWIDTH_GLB-1:0] r_addr,
  output logic [DATA_BITWIDTH-1:0]     r_data,
  output logic                         r_valid,
  output logic                         busy,
  output logic                         ovf,
  output logic                         addr_err
);
  localparam int DW = DATA_BITWIDTH;
  localparam int AW = ADDR_BITWIDTH_GLB;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   clr_cnt;
  logic [DW-1:0]   mem [DEPTH];

  logic            s1_vld, s1_acc;
  logic [IW-1:0]   s1_addr;
  logic [DW-1:0]   s1_data, s1_old;

  logic [DW:0]     sum_ext;
  logic [DW-1:0]   sum;
  logic            sat_hit;

  logic            idle_go, w_in, r_in, w_ok, r_ok, w_bad, r_bad, commit;
  logic [IW-1:0]   w_idx, r_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (!clear && clr_cnt == IW'(DEPTH-1)) state_nxt = IDLE;
      IDLE:  if (clear) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clear || state == IDLE) clr_cnt <= '0;
      else                        clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign busy    = (state == CLEAR);
  // A clear pulse in IDLE suppresses everything that cycle, including the in-flight commit.
  assign idle_go = (state == IDLE) && !clear;
  assign w_in    = {1'b0, w_addr_glb_psum} < (AW+1)'(DEPTH);
  assign r_in    = {1'b0, r_addr} < (AW+1)'(DEPTH);
  assign w_ok    = idle_go && write_en_glb_psum && w_in;
  assign w_bad   = idle_go && write_en_glb_psum && !w_in;
  assign r_ok    = idle_go && read_en && r_in;
  assign r_bad   = idle_go && read_en && !r_in;
  assign commit  = s1_vld && idle_go;
  assign w_idx   = w_addr_glb_psum[IW-1:0];
  assign r_idx   = r_addr[IW-1:0];

  // Sum at DW+1 bits; the two top bits disagree exactly when the signed result overflowed.
  always_comb begin
    sum_ext = {s1_old[DW-1], s1_old} + {s1_data[DW-1], s1_data};
    sat_hit = 1'b0;
    sum     = s1_data;
    if (s1_acc) begin
      if (sum_ext[DW] != sum_ext[DW-1]) begin
        sat_hit = 1'b1;
        sum     = sum_ext[DW] ? SAT_MIN : SAT_MAX;
      end else begin
        sum = sum_ext[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clr_cnt] <= '0;
    else if (commit)     mem[s1_addr] <= sum;
  end

  // Old value is captured in stage 1; forward the stage-2 result when it targets the same entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld  <= 1'b0;
      s1_acc  <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_old  <= '0;
    end else begin
      s1_vld <= w_ok;
      if (w_ok) begin
        s1_addr <= w_idx;
        s1_data <= w_data_glb_psum;
        s1_acc  <= accum_en;
        s1_old  <= (commit && s1_addr == w_idx) ? sum : mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      ovf      <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      r_valid <= r_ok;
      if (r_ok) r_data <= (commit && s1_addr == r_idx) ? sum : mem[r_idx];
      if (clear) begin
        ovf      <= 1'b0;
        addr_err <= 1'b0;
      end else begin
        if (commit && sat_hit) ovf      <= 1'b1;
        if (w_bad || r_bad)    addr_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_glb_psum_accum.sv
// Randomized + directed bench for glb_psum_accum against an array-based reference model.
module tb_glb_psum_accum;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          write_en_glb_psum;
  logic [AW-1:0] w_addr_glb_psum;
  logic [DW-1:0] w_data_glb_psum;
  logic          accum_en;
  logic          clear;
  logic          read_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          busy;
  logic          ovf;
  logic          addr_err;

  int n_checks = 0;
  int n_errors = 0;

  int mdl [DEPTH];
  bit m_ovf;
  bit m_err;

  glb_psum_accum #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .write_en_glb_psum(write_en_glb_psum), .w_addr_glb_psum(w_addr_glb_psum),
    .w_data_glb_psum(w_data_glb_psum), .accum_en(accum_en), .clear(clear),
    .read_en(read_en), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .busy(busy), .ovf(ovf), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat16(input int v, output bit clipped);
    clipped = 1'b0;
    if (v > 32767)       begin clipped = 1'b1; return 32767;  end
    else if (v < -32768) begin clipped = 1'b1; return -32768; end
    return v;
  endfunction

  task automatic idle_inputs();
    write_en_glb_psum = 1'b0; w_addr_glb_psum = '0; w_data_glb_psum = '0;
    accum_en = 1'b0; clear = 1'b0; read_en = 1'b0; r_addr = '0;
  endtask

  task automatic model_zero();
    foreach (mdl[i]) mdl[i] = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  // One IDLE-state cycle; reads see the model before this cycle's write is applied.
  task automatic cyc(input bit we, input int wa, input int wd, input bit acc,
                     input bit re, input int ra, input bit clr);
    bit exp_v;
    int exp_d;
    bit clip;
    write_en_glb_psum = we; w_addr_glb_psum = AW'(wa); w_data_glb_psum = DW'(wd);
    accum_en = acc; read_en = re; r_addr = AW'(ra); clear = clr;
    exp_v = re && (ra < DEPTH) && !clr;
    exp_d = exp_v ? mdl[ra] : 0;
    if (clr) begin
      model_zero();
    end else begin
      if (we) begin
        if (wa < DEPTH) begin
          if (acc) begin
            mdl[wa] = sat16(mdl[wa] + wd, clip);
            if (clip) m_ovf = 1'b1;
          end else begin
            mdl[wa] = wd;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (re && ra >= DEPTH) m_err = 1'b1;
    end
    @(posedge clk); #1;
    idle_inputs();
    check("r_valid", int'(r_valid), int'(exp_v));
    if (exp_v) check($sformatf("r_data[%0d]", ra), int'($signed(r_data)), exp_d);
  endtask

  task automatic wait_busy(input bit junk);
    int n = 0;
    while (busy && n < 200) begin
      if (junk) begin
        write_en_glb_psum = 1'($urandom); w_addr_glb_psum = AW'($urandom);
        w_data_glb_psum = DW'($urandom); accum_en = 1'($urandom);
        read_en = 1'($urandom); r_addr = AW'($urandom);
      end
      n++;
      @(posedge clk); #1;
      check("busy_rvalid", int'(r_valid), 0);
    end
    idle_inputs();
    check("busy_len", n, DEPTH);
    model_zero();
    check("ovf_after_clear", int'(ovf), 0);
    check("err_after_clear", int'(addr_err), 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, 0, 1, a, 0);
  endtask

  function automatic int rnd_data();
    case ($urandom_range(0, 3))
      0:       return 32767 - int'($urandom_range(0, 3));
      1:       return -32768 + int'($urandom_range(0, 3));
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic int rnd_addr();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(DEPTH, 1023));
    if ($urandom_range(0, 1) == 0)  return int'($urandom_range(0, 3));
    return int'($urandom_range(0, DEPTH-1));
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_valid", int'(r_valid), 0);
    check("rst_r_data", int'(r_data), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_addr_err", int'(addr_err), 0);
    check("rst_busy", int'(busy), 1);
    reset = 1'b1;
    wait_busy(1'b0);
    read_all();

    // Store then accumulate with forwarding into the following read.
    cyc(1, 5, 100, 0, 0, 0, 0);
    cyc(1, 5, -30, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 5, 0);
    check("addr5_model", mdl[5], 70);

    cyc(1, 3, 1, 1, 0, 0, 0);
    cyc(1, 3, 2, 1, 0, 0, 0);
    cyc(1, 3, 3, 1, 1, 3, 0);
    cyc(0, 0, 0, 0, 1, 3, 0);

    cyc(1, 7, 32767, 0, 0, 0, 0);
    cyc(1, 7, 1, 1, 0, 0, 0);
    cyc(1, 8, -32768, 0, 0, 0, 0);
    cyc(1, 8, -1, 1, 1, 7, 0);
    cyc(0, 0, 0, 0, 1, 8, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("ovf_sat", int'(ovf), int'(m_ovf));
    check("err_before_bad", int'(addr_err), 0);

    cyc(1, 70, 1234, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("addr_err_set", int'(addr_err), 1);
    for (int a = 0; a < 12; a++) cyc(0, 0, 0, 0, 1, a, 0);
    cyc(0, 0, 0, 0, 1, 70, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("busy_after_clear", int'(busy), 1);
    wait_busy(1'b1);
    read_all();

    // Random traffic with hazards concentrated on a few addresses.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 9) < 7), rnd_addr(), rnd_data(), 1'($urandom),
          ($urandom_range(0, 9) < 6), rnd_addr(), 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rand_ovf", int'(ovf), int'(m_ovf));
    check("rand_addr_err", int'(addr_err), int'(m_err));
    read_all();

    // Clear with writes in flight, then reset partway through the clear sweep.
    for (int i = 0; i < 8; i++) cyc(1, rnd_addr() % DEPTH, rnd_data(), 1'($urandom), 0, 0, 0);
    cyc(1, 9, 555, 0, 0, 0, 1);
    repeat (20) begin
      write_en_glb_psum = 1'b1; w_addr_glb_psum = AW'($urandom_range(0, DEPTH-1));
      w_data_glb_psum = DW'($urandom);
      @(posedge clk); #1;
    end
    idle_inputs();
    check("busy_mid_clear", int'(busy), 1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_busy(1'b1);
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
